mult_issue_ctrl: RTL and testbench

//  Operand sequencer and result buffer that wraps the 32x32 iterative multiply unit.

---
 rtl/mult_issue_if.sv | 33 +++
 rtl/mult_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_issue_if.sv
// Signal bundle between the multiply issue controller, its operand source,
// the iterative multiplier and the result consumer.
interface mult_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        out_overflow;
  logic        err_timeout;
  logic        err_spurious;
  logic        busy;

  modport slave (
    input  in_valid, in_op1, in_op2, product, mult_end, overflow, out_ready,
    output in_ready, mult_begin, mult_op1, mult_op2, out_valid, out_product,
           out_overflow, err_timeout, err_spurious, busy
  );

  modport master (
    output in_valid, in_op1, in_op2, product, mult_end, overflow, out_ready,
    input  in_ready, mult_begin, mult_op1, mult_op2, out_valid, out_product,
           out_overflow, err_timeout, err_spurious, busy
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Operand FIFO + issue sequencer + result register around a 32x32 iterative
// multiplier using a level begin/end handshake, with an abort watchdog.
//
// state | meaning
// IDLE  | no operation in flight, waiting for an operand pair and a free result slot
// ISSUE | mult_begin held high, waiting for mult_end or watchdog expiry
// GAP   | one cycle with mult_begin low so the multiplier can restart
module mult_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic         clk,
  input logic         resetn,
  mult_issue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        fifo_op1_q [DEPTH];
  logic [31:0]        fifo_op2_q [DEPTH];
  logic [WD_W-1:0]    wd_q;
  logic               mult_begin_q;
  logic [31:0]        mult_op1_q, mult_op2_q;
  logic               out_valid_q;
  logic [63:0]        out_product_q;
  logic               out_overflow_q;
  logic               err_timeout_q;
  logic               err_spurious_q;

  logic fifo_empty, in_ready, push, out_free, wd_done;
  logic load, capture, abort, pop, spurious;

  assign fifo_empty = (count_q == '0);
  // Full is judged on the registered count only; a same-cycle pop does not free a slot.
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign push       = bus.in_valid & in_ready;
  assign out_free   = ~out_valid_q | bus.out_ready;
  assign wd_done    = (wd_q == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty && out_free) state_d = S_ISSUE;
      S_ISSUE: if (bus.mult_end || wd_done) state_d = S_GAP;
      S_GAP:   state_d = (!fifo_empty && out_free) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / strobe logic; mult_end wins over the watchdog in the same cycle
  always_comb begin
    load     = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    spurious = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        load     = (state_d == S_ISSUE);
        spurious = bus.mult_end;
      end
      S_ISSUE: begin
        capture = bus.mult_end;
        abort   = ~bus.mult_end & wd_done;
      end
      default: ;
    endcase
    pop = capture | abort;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op1_q[wr_ptr_q] <= bus.in_op1;
      fifo_op2_q[wr_ptr_q] <= bus.in_op2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The head entry stays in the FIFO while in flight; it is popped on leaving ISSUE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mult_begin_q <= 1'b0;
      mult_op1_q   <= '0;
      mult_op2_q   <= '0;
      wd_q         <= '0;
    end else begin
      if (load) begin
        mult_begin_q <= 1'b1;
        mult_op1_q   <= fifo_op1_q[rd_ptr_q];
        mult_op2_q   <= fifo_op2_q[rd_ptr_q];
        wd_q         <= '0;
      end else begin
        if (pop)                mult_begin_q <= 1'b0;
        if (state_q == S_ISSUE) wd_q         <= wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q    <= 1'b0;
      out_product_q  <= '0;
      out_overflow_q <= 1'b0;
    end else if (capture) begin
      out_valid_q    <= 1'b1;
      out_product_q  <= bus.product;
      out_overflow_q <= bus.overflow;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      if (abort)    err_timeout_q  <= 1'b1;
      if (spurious) err_spurious_q <= 1'b1;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mult_begin   = mult_begin_q;
  assign bus.mult_op1     = mult_op1_q;
  assign bus.mult_op2     = mult_op2_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_product  = out_product_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_spurious = err_spurious_q;
  assign bus.busy         = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural iterative multiplier
// whose latency and hang behaviour are set per step.
module tb_mult_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk;
  logic resetn;
  mult_issue_if bus();

  mult_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural multiplier: raises end after lat cycles of begin unless hung.
  int          lat  = 33;
  bit          hang = 1'b0;
  bit          spur = 1'b0;
  logic        m_end_q  = 1'b0;
  logic [63:0] m_prod_q = '0;
  int          m_cnt    = 0;

  always @(posedge clk) begin
    if (!bus.mult_begin) begin
      m_cnt   <= 0;
      m_end_q <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= lat && !hang) begin
        m_end_q  <= 1'b1;
        m_prod_q <= 64'(bus.mult_op1) * 64'(bus.mult_op2);
      end
    end
  end

  assign bus.mult_end = (m_end_q & bus.mult_begin) | spur;
  assign bus.product  = m_prod_q;
  assign bus.overflow = |m_prod_q[63:32];

  // Observers: accepted results, and lengths of mult_begin high/low runs.
  logic [63:0] res_prod [$];
  logic        res_ovf  [$];
  int          lows     [$];
  int          highs    [$];
  int          low_run  = 0;
  int          high_run = 0;
  logic        prev_begin = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      res_prod.push_back(bus.out_product);
      res_ovf.push_back(bus.out_overflow);
    end
    if (bus.mult_begin) begin
      if (!prev_begin) begin
        lows.push_back(low_run);
        high_run = 0;
      end
      high_run++;
    end else begin
      if (prev_begin) begin
        highs.push_back(high_run);
        low_run = 0;
      end
      low_run++;
    end
    prev_begin = bus.mult_begin;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_op1   = a;
    bus.in_op2   = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic clear_obs();
    res_prod.delete();
    res_ovf.delete();
    lows.delete();
    highs.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  int n_acc;
  bit acc3;

  initial begin
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_begin",     64'(bus.mult_begin),   64'd0);
    check("rst_op1",       64'(bus.mult_op1),     64'd0);
    check("rst_out_valid", 64'(bus.out_valid),    64'd0);
    check("rst_product",   bus.out_product,       64'd0);
    check("rst_in_ready",  64'(bus.in_ready),     64'd1);
    check("rst_busy",      64'(bus.busy),         64'd0);
    check("rst_err_to",    64'(bus.err_timeout),  64'd0);
    check("rst_err_sp",    64'(bus.err_spurious), 64'd0);
    resetn = 1'b1;

    // 1: single large operand pair, 33-cycle multiplier
    lat = 33;
    clear_obs();
    push(32'h7fffffff, 32'h7fffffff);
    check("t1_begin_pre", 64'(bus.mult_begin), 64'd0);
    @(posedge clk); #1;
    check("t1_begin_lat", 64'(bus.mult_begin), 64'd1);
    check("t1_op1",       64'(bus.mult_op1),   64'h7fffffff);
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin @(posedge clk); #1; end
    check("t1_out_valid", 64'(bus.out_valid),    64'd1);
    check("t1_begin_end", 64'(bus.mult_begin),   64'd0);
    check("t1_product",   bus.out_product,       64'h3FFFFFFF00000001);
    check("t1_overflow",  64'(bus.out_overflow), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t1_pulses",    64'(res_prod.size()), 64'd1);
    check("t1_valid_clr", 64'(bus.out_valid),   64'd0);

    // 2: three back-to-back ops, one-cycle gap between them
    lat = 5;
    clear_obs();
    push(32'd3, 32'd5);
    push(32'hFFFFFFFF, 32'd2);
    push(32'd0, 32'd9);
    for (int i = 0; i < 200 && res_prod.size() < 3; i++) begin @(posedge clk); #1; end
    check("t2_count", 64'(res_prod.size()), 64'd3);
    check("t2_res0",  res_prod[0], 64'd15);
    check("t2_res1",  res_prod[1], 64'h1FFFFFFFE);
    check("t2_ovf1",  64'(res_ovf[1]), 64'd1);
    check("t2_res2",  res_prod[2], 64'd0);
    check("t2_issues", 64'(lows.size()), 64'd3);
    check("t2_gap1",  64'(lows[1]), 64'd1);
    check("t2_gap2",  64'(lows[2]), 64'd1);

    // 3: consumer stalled, offer DEPTH+2 pairs
    lat = 3;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_obs();
    n_acc = 0;
    bus.in_valid = 1'b1;
    bus.in_op1   = 32'd1;
    bus.in_op2   = 32'd10;
    for (int c = 0; c < 30; c++) begin
      acc3 = bus.in_ready;
      @(posedge clk); #1;
      if (acc3) begin
        n_acc++;
        bus.in_op1 = 32'(n_acc + 1);
      end
      if (n_acc == DEPTH + 2) break;
    end
    bus.in_valid = 1'b0;
    check("t3_accepted",  64'(n_acc),          64'(DEPTH + 1));
    check("t3_in_ready",  64'(bus.in_ready),   64'd0);
    check("t3_held",      64'(bus.out_valid),  64'd1);
    check("t3_held_prod", bus.out_product,     64'd10);
    check("t3_begin",     64'(bus.mult_begin), 64'd0);
    check("t3_issues",    64'(lows.size()),    64'd1);
    check("t3_busy",      64'(bus.busy),       64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && res_prod.size() < DEPTH + 1; i++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1;
    check("t3_count", 64'(res_prod.size()), 64'(DEPTH + 1));
    for (int i = 0; i < DEPTH + 1; i++)
      check("t3_res", res_prod[i], 64'(10 * (i + 1)));

    // 4: multiplier hangs on the first op, second op completes
    lat  = 3;
    hang = 1'b1;
    clear_obs();
    push(32'd6, 32'd7);
    push(32'd8, 32'd9);
    for (int i = 0; i < 200 && !bus.err_timeout; i++) begin @(posedge clk); #1; end
    hang = 1'b0;
    check("t4_err_to",    64'(bus.err_timeout), 64'd1);
    check("t4_no_valid",  64'(bus.out_valid),   64'd0);
    check("t4_begin_low", 64'(bus.mult_begin),  64'd0);
    for (int i = 0; i < 100 && res_prod.size() < 1; i++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1;
    check("t4_high_len", 64'(highs[0]),         64'(TIMEOUT));
    check("t4_gap",      64'(lows[1]),          64'd1);
    check("t4_count",    64'(res_prod.size()),  64'd1);
    check("t4_res",      res_prod[0],           64'd72);

    // 5: reset while an op is in flight with two queued
    lat = 20;
    push(32'd1, 32'd2);
    push(32'd3, 32'd4);
    push(32'd5, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    check("t5_in_flight", 64'(bus.mult_begin), 64'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t5_begin",    64'(bus.mult_begin),  64'd0);
    check("t5_valid",    64'(bus.out_valid),   64'd0);
    check("t5_in_ready", 64'(bus.in_ready),    64'd1);
    check("t5_busy",     64'(bus.busy),        64'd0);
    check("t5_err_to",   64'(bus.err_timeout), 64'd0);
    resetn = 1'b1;
    clear_obs();
    repeat (60) @(posedge clk);
    #1;
    check("t5_no_result", 64'(res_prod.size()), 64'd0);
    check("t5_no_issue",  64'(lows.size()),     64'd0);

    // 6: stray mult_end while idle
    check("t6_err_sp_pre", 64'(bus.err_spurious), 64'd0);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check("t6_err_sp",   64'(bus.err_spurious), 64'd1);
    check("t6_valid",    64'(bus.out_valid),    64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_result", 64'(res_prod.size()), 64'd0);
    check("t6_begin",     64'(bus.mult_begin),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
